// File: rtl/dcim_seq_ctrl.sv
// Command sequencer for a digital compute-in-memory array. It streams weight
// loads and compute operands into the array and returns products through a small in-order FIFO.
module dcim_seq_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_COUNT   = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int MULT_WIDTH   = 2 * DATA_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int INIT_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  pe_ce,
    output logic                  pe_init_enable,
    output logic [DATA_WIDTH-1:0] pe_data,
    input  logic                  pe_valid_out,
    input  logic [MULT_WIDTH-1:0] pe_data_out,
    input  logic                  pe_init_done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [MULT_WIDTH-1:0] res_data,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done,
    output logic                  weights_loaded,
    output logic [2:0]            err
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = OCC_W + 1;
    localparam int TMR_W = $clog2(INIT_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] WORDS    = CNT_W'(ADDR_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [SUM_W-1:0] DEPTH    = SUM_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(INIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_INIT,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      load_cnt;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      res_cnt;
    logic [OCC_W-1:0]      outstanding;
    logic [OCC_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [TMR_W-1:0]      init_timer;
    logic [MULT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic in_accept;
    logic issue_compute;
    logic pe_return;
    logic fifo_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign in_accept     = in_valid && in_ready;
    assign issue_compute = in_accept && (state == S_COMPUTE);
    // A product with nothing outstanding is spurious and must never reach the FIFO.
    assign pe_return     = pe_valid_out && (outstanding != '0);
    assign res_valid     = (fifo_count != '0);
    assign fifo_pop      = res_valid && res_ready;
    assign res_data      = res_valid ? fifo_mem[rd_ptr] : '0;
    assign res_last      = res_valid && ((res_cnt + CNT_ONE) == len_q);

    // Compute admission counts products still in flight plus those already
    // buffered, so a returning product always finds a free FIFO slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        in_ready = 1'b0;
        case (state)
            S_LOAD:    in_ready = (load_cnt < WORDS);
            S_COMPUTE: in_ready = (issued < len_q) &&
                                  (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH);
            default:   in_ready = 1'b0;
        endcase
    end

    // NOTE: the FIFO storage has no reset; fifo_count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (pe_return) fifo_mem[wr_ptr] <= pe_data_out;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
        if (rst) begin
            state          <= S_IDLE;
            load_cnt       <= '0;
            issued         <= '0;
            len_q          <= '0;
            res_cnt        <= '0;
            outstanding    <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            init_timer     <= '0;
            pe_ce          <= 1'b0;
            pe_init_enable <= 1'b0;
            pe_data        <= '0;
            done           <= 1'b0;
            weights_loaded <= 1'b0;
            err            <= '0;
        end else begin
            done           <= 1'b0;
            pe_ce          <= in_accept;
            pe_init_enable <= in_accept && (state == S_LOAD);
            if (in_accept) pe_data <= in_data;

            if (issue_compute && !pe_return)      outstanding <= outstanding + OCC_ONE;
            else if (!issue_compute && pe_return) outstanding <= outstanding - OCC_ONE;

            if (pe_valid_out && (outstanding == '0)) err[1] <= 1'b1;

            if (pe_return) wr_ptr <= ptr_next(wr_ptr);
            if (fifo_pop) begin
                rd_ptr  <= ptr_next(rd_ptr);
                res_cnt <= res_cnt + CNT_ONE;
            end
            if (pe_return && !fifo_pop)      fifo_count <= fifo_count + OCC_ONE;
            else if (!pe_return && fifo_pop) fifo_count <= fifo_count - OCC_ONE;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (!cmd_op) begin
                            state          <= S_LOAD;
                            weights_loaded <= 1'b0;
                            load_cnt       <= '0;
                        end else if (weights_loaded) begin
                            state   <= S_COMPUTE;
                            len_q   <= (cmd_len == '0) ? WORDS : {1'b0, cmd_len};
                            issued  <= '0;
                            res_cnt <= '0;
                        end else begin
                            err[0] <= 1'b1;
                            done   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_accept) begin
                        load_cnt <= load_cnt + CNT_ONE;
                        if (load_cnt == (WORDS - CNT_ONE)) begin
                            state      <= S_WAIT_INIT;
                            init_timer <= '0;
                        end
                    end
                end
                S_WAIT_INIT: begin
                    if (pe_init_done) begin
                        weights_loaded <= 1'b1;
                        done           <= 1'b1;
                        state          <= S_IDLE;
                    end else if (init_timer == TMO_LAST) begin
                        err[2] <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        init_timer <= init_timer + TMR_ONE;
                    end
                end
                S_COMPUTE: begin
                    if (in_accept) begin
                        issued <= issued + CNT_ONE;
                        if ((issued + CNT_ONE) == len_q) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((outstanding == '0) && (fifo_count == '0)) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcim_seq_ctrl.sv
// Directed bench for dcim_seq_ctrl: a 3-cycle-latency array model plus load,
// compute, backpressure, error and reset scenarios checked with immediate assertions.
module tb_dcim_seq_ctrl;

    localparam int DW = 32;
    localparam int AC = 64;
    localparam int AW = 6;
    localparam int MW = 64;
    localparam int FD = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          pe_ce;
    logic          pe_init_enable;
    logic [DW-1:0] pe_data;
    logic          pe_valid_out;
    logic [MW-1:0] pe_data_out;
    logic          pe_init_done;
    logic          res_valid;
    logic          res_ready;
    logic [MW-1:0] res_data;
    logic          res_last;
    logic          busy;
    logic          done;
    logic          weights_loaded;
    logic [2:0]    err;

    int checks = 0;
    int errors = 0;

    dcim_seq_ctrl #(
        .DATA_WIDTH(DW), .ADDR_COUNT(AC), .ADDR_WIDTH(AW),
        .MULT_WIDTH(MW), .FIFO_DEPTH(FD), .INIT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pe_ce(pe_ce), .pe_init_enable(pe_init_enable), .pe_data(pe_data),
        .pe_valid_out(pe_valid_out), .pe_data_out(pe_data_out), .pe_init_done(pe_init_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done), .weights_loaded(weights_loaded), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] prod(input logic [DW-1:0] d);
        return 64'(d) * 64'h0000_0000_0001_0003;
    endfunction

    // Array model: compute words return a product three cycles later; load words return nothing.
    logic [2:0]    v_pipe = '0;
    logic [MW-1:0] d_pipe [3];
    logic          spur = 1'b0;

    always @(posedge clk) begin
        v_pipe    <= {v_pipe[1:0], pe_ce && !pe_init_enable};
        d_pipe[0] <= prod(pe_data);
        d_pipe[1] <= d_pipe[0];
        d_pipe[2] <= d_pipe[1];
    end

    assign pe_valid_out = v_pipe[2] | spur;
    assign pe_data_out  = d_pipe[2];

    logic [DW-1:0] load_q [$];
    logic [MW:0]   res_q [$];
    int            ce_cnt = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (pe_ce && pe_init_enable) load_q.push_back(pe_data);
        if (pe_ce) ce_cnt++;
        if (res_valid && res_ready) res_q.push_back({res_last, res_data});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_cmd(input logic op, input logic [AW-1:0] len);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        while (!cmd_ready && g < 100) begin
            tick();
            g++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Offers consecutive words base, base+1, ... until n are accepted or max_cycles pass.
    task automatic stream(input int n, input int base, input int max_cycles, output int acc);
        logic ready_now;
        acc = 0;
        for (int c = 0; c < max_cycles && acc < n; c++) begin
            in_valid  = 1'b1;
            in_data   = DW'(base + acc);
            ready_now = in_ready;
            tick();
            if (ready_now) acc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int g = 0;
        while (!done && g < max_cycles) begin
            tick();
            g++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_cmd_ready"},      64'(cmd_ready),      64'd1);
        check({p, "_in_ready"},       64'(in_ready),       64'd0);
        check({p, "_pe_ce"},          64'(pe_ce),          64'd0);
        check({p, "_pe_init_enable"}, 64'(pe_init_enable), 64'd0);
        check({p, "_pe_data"},        64'(pe_data),        64'd0);
        check({p, "_res_valid"},      64'(res_valid),      64'd0);
        check({p, "_res_data"},       res_data,            64'd0);
        check({p, "_res_last"},       64'(res_last),       64'd0);
        check({p, "_busy"},           64'(busy),           64'd0);
        check({p, "_done"},           64'(done),           64'd0);
        check({p, "_weights_loaded"}, 64'(weights_loaded), 64'd0);
        check({p, "_err"},            64'(err),            64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int d0;
        int d1;

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 1'b0;
        cmd_len      = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        pe_init_done = 1'b0;
        res_ready    = 1'b0;
        tick();
        tick();
        check_reset_vals("rst0");
        rst = 1'b0;

        // COMPUTE before any LOAD: flagged, one done pulse, nothing issued.
        d0 = done_cnt;
        send_cmd(1'b1, 6'd5);
        check("unl_done_pulse", 64'(done), 64'd1);
        check("unl_err", 64'(err), 64'h1);
        check("unl_idle", 64'(busy), 64'd0);
        tick();
        tick();
        tick();
        check("unl_done_once", 64'(done_cnt - d0), 64'd1);
        check("unl_no_ce", 64'(ce_cnt), 64'd0);
        check("unl_err_sticky", 64'(err), 64'h1);

        // Full weight load 0..63, init_done returned shortly after the last word.
        do_reset();
        load_q.delete();
        d0 = done_cnt;
        send_cmd(1'b0, 6'd0);
        check("load_busy", 64'(busy), 64'd1);
        check("load_in_ready", 64'(in_ready), 64'd1);
        stream(AC, 0, 200, acc);
        check("load_accepted", 64'(acc), 64'(AC));
        check("load_in_ready_low", 64'(in_ready), 64'd0);
        check("load_wl_low", 64'(weights_loaded), 64'd0);
        tick();
        tick();
        pe_init_done = 1'b1;
        tick();
        pe_init_done = 1'b0;
        check("load_done_pulse", 64'(done), 64'd1);
        check("load_wl_set", 64'(weights_loaded), 64'd1);
        check("load_idle", 64'(busy), 64'd0);
        tick();
        check("load_pulses", 64'(load_q.size()), 64'(AC));
        for (int i = 0; i < load_q.size(); i++)
            check($sformatf("load_word_%0d", i), 64'(load_q[i]), 64'(i));
        check("load_done_once", 64'(done_cnt - d0), 64'd1);

        // COMPUTE with cmd_len=0 (full 64 words), sink always ready.
        res_q.delete();
        d0 = done_cnt;
        d1 = ce_cnt;
        res_ready = 1'b1;
        send_cmd(1'b1, 6'd0);
        stream(AC, 1000, 1000, acc);
        check("c64_accepted", 64'(acc), 64'(AC));
        wait_done("c64_done", 200);
        check("c64_busy_low", 64'(busy), 64'd0);
        tick();
        check("c64_count", 64'(res_q.size()), 64'(AC));
        for (int i = 0; i < res_q.size(); i++) begin
            check($sformatf("c64_data_%0d", i), res_q[i][MW-1:0], prod(DW'(1000 + i)));
            check($sformatf("c64_last_%0d", i), 64'(res_q[i][MW]), (i == AC - 1) ? 64'd1 : 64'd0);
        end
        check("c64_ce", 64'(ce_cnt - d1), 64'(AC));
        check("c64_done_once", 64'(done_cnt - d0), 64'd1);

        // COMPUTE of 10 words against a stalled sink: admission stops at the FIFO depth.
        res_q.delete();
        d0 = done_cnt;
        d1 = ce_cnt;
        res_ready = 1'b0;
        send_cmd(1'b1, 6'd10);
        stream(10, 2000, 20, acc);
        check("c10_stall_issued", 64'(acc), 64'(FD));
        check("c10_in_ready_low", 64'(in_ready), 64'd0);
        check("c10_res_valid", 64'(res_valid), 64'd1);
        check("c10_head", res_data, prod(DW'(2000)));
        check("c10_head_last", 64'(res_last), 64'd0);
        tick();
        tick();
        tick();
        check("c10_head_held", res_data, prod(DW'(2000)));
        check("c10_still_blocked", 64'(in_ready), 64'd0);
        res_ready = 1'b1;
        stream(10 - FD, 2000 + FD, 200, acc);
        check("c10_rest_issued", 64'(acc), 64'(10 - FD));
        wait_done("c10_done", 200);
        tick();
        check("c10_count", 64'(res_q.size()), 64'd10);
        for (int i = 0; i < res_q.size(); i++) begin
            check($sformatf("c10_data_%0d", i), res_q[i][MW-1:0], prod(DW'(2000 + i)));
            check($sformatf("c10_last_%0d", i), 64'(res_q[i][MW]), (i == 9) ? 64'd1 : 64'd0);
        end
        check("c10_ce", 64'(ce_cnt - d1), 64'd10);
        check("c10_done_once", 64'(done_cnt - d0), 64'd1);

        // A product with nothing outstanding is flagged and dropped.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_err", 64'(err), 64'h2);
        check("spur_not_pushed", 64'(res_valid), 64'd0);

        // Reset in the middle of a load, then a COMPUTE that must be refused.
        do_reset();
        send_cmd(1'b0, 6'd0);
        stream(30, 500, 100, acc);
        check("midload_accepted", 64'(acc), 64'd30);
        rst = 1'b1;
        tick();
        check_reset_vals("midload");
        rst = 1'b0;
        d1 = ce_cnt;
        send_cmd(1'b1, 6'd5);
        check("post_rst_err", 64'(err), 64'h1);
        check("post_rst_done", 64'(done), 64'd1);
        tick();
        tick();
        check("post_rst_no_ce", 64'(ce_cnt - d1), 64'd0);

        // Load with no init_done: timeout fires exactly INIT_TIMEOUT cycles into WAIT_INIT.
        do_reset();
        send_cmd(1'b0, 6'd0);
        stream(AC, 0, 200, acc);
        check("tmo_accepted", 64'(acc), 64'(AC));
        repeat (TO - 1) tick();
        check("tmo_not_yet", 64'(err), 64'h0);
        check("tmo_still_busy", 64'(busy), 64'd1);
        tick();
        check("tmo_err", 64'(err), 64'h4);
        check("tmo_done", 64'(done), 64'd1);
        check("tmo_wl_low", 64'(weights_loaded), 64'd0);
        check("tmo_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcim_seq_ctrl.md
DCIM_SEQ_CTRL -- requirements
Module: dcim_seq_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 32, operand width; ADDR_COUNT, 64, SRAM word count; ADDR_WIDTH, 6, log2(ADDR_COUNT); MULT_WIDTH, 2*DATA_WIDTH, product width; FIFO_DEPTH, 4, result buffer depth; INIT_TIMEOUT, 16, cycles allowed for init_done.
REQ-002 One clock and one reset: reset is synchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  sync active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  1  0=LOAD weights, 1=COMPUTE
- cmd_len  in  ADDR_WIDTH  COMPUTE word count; 0 means ADDR_COUNT; ignored for LOAD
- in_valid / in_ready  in / out  1  operand stream handshake
- in_data  in  DATA_WIDTH  operand word
- pe_ce  out  1  DCIM array enable
- pe_init_enable  out  1  array write (load) strobe
- pe_data  out  DATA_WIDTH  word to array
- pe_valid_out  in  1  array product valid
- pe_data_out  in  MULT_WIDTH  array product
- pe_init_done  in  1  array load complete
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  MULT_WIDTH  product
- res_last  out  1  final result of current COMPUTE
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at command completion
- weights_loaded  out  1  valid weight set present
- err  out  3  sticky {timeout, spurious, unloaded}

Function
REQ-004 States SHALL be IDLE, LOAD, WAIT_INIT, COMPUTE, DRAIN.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command is taken on cmd_valid&&cmd_ready.
REQ-006 IDLE + LOAD cmd -> LOAD; clear weights_loaded and the load counter.
REQ-007 IDLE + COMPUTE cmd with weights_loaded=1 -> COMPUTE, latching len (0 -> ADDR_COUNT).
REQ-008 IDLE + COMPUTE cmd with weights_loaded=0 -> set err[0], pulse done next cycle, remain IDLE, issue nothing.
REQ-009 pe_ce, pe_init_enable and pe_data SHALL be registered: a word accepted in cycle t appears on pe_data in cycle t+1 with pe_ce=1.
REQ-010 pe_ce SHALL be 1 only in cycles carrying an accepted word; otherwise 0. pe_data holds its last value when pe_ce=0.
REQ-011 LOAD: in_ready=1 until ADDR_COUNT words are accepted; pe_init_enable=1 with each issued word; after word ADDR_COUNT-1 -> WAIT_INIT.
REQ-012 WAIT_INIT: pe_init_done=1 -> set weights_loaded, pulse done, go to IDLE. INIT_TIMEOUT cycles with no init_done -> set err[2], pulse done, go to IDLE with weights_loaded=0.
REQ-013 COMPUTE: pe_init_enable=0. in_ready = (issued < len) && (outstanding + fifo_count < FIFO_DEPTH).
REQ-014 outstanding SHALL increment on each issued word and decrement on pe_valid_out. Both in the same cycle -> unchanged.
REQ-015 pe_valid_out SHALL push pe_data_out into the FIFO; it never overflows because of REQ-013.
REQ-016 pe_valid_out with outstanding=0 SHALL set err[1] and SHALL NOT push.
REQ-017 Results SHALL leave the FIFO in order. res_data and res_last are held stable while res_valid && !res_ready.
REQ-018 res_last=1 on the len-th result of the command.
REQ-019 Once issued == len -> DRAIN.
REQ-020 DRAIN: when outstanding=0 and the FIFO is empty after the res_last transfer, pulse done and go to IDLE.
REQ-021 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 err bits are sticky until rst. A new command does not clear them.

Reset
REQ-023 rst=1 at any clock edge, including mid-LOAD or mid-COMPUTE, SHALL force the following on the next edge:
- state IDLE
- all counters and the FIFO emptied
- outputs: cmd_ready=1, in_ready=0, pe_ce=0, pe_init_enable=0, pe_data=0, res_valid=0, res_data=0, res_last=0, busy=0, done=0, weights_loaded=0, err=0.
REQ-024 Products arriving after reset SHALL be treated per REQ-016.

Verification
REQ-025 Reset then LOAD of 64 words 0..63 with pe_init_done returned 2 cycles after the last word -> exactly 64 pe_init_enable pulses carrying data 0..63; weights_loaded=1; one done pulse.
REQ-026 COMPUTE with cmd_len=0 and res_ready=1, array latency 3 -> 64 in-order results; res_last only on the 64th; done pulse; busy low afterwards.
REQ-027 COMPUTE with cmd_len=10 and res_ready held 0 -> in_ready drops after 4 issued words with FIFO full. Releasing res_ready -> all 10 results delivered with no loss; res_last on the 10th.
REQ-028 COMPUTE issued before any LOAD -> err=3'b001, no pe_ce pulse, done pulse, state stays IDLE.
REQ-029 rst asserted after 30 LOAD words -> all outputs at reset values next cycle; weights_loaded=0. A subsequent COMPUTE sets err[0].
REQ-030 LOAD with pe_init_done never asserted -> err[2] set exactly INIT_TIMEOUT cycles after entering WAIT_INIT; weights_loaded=0.
